// File: rtl/psum_idx_pkg.sv
// Shared types and default widths for the psum index sequencer slice.
package psum_idx_pkg;

  localparam int unsigned F_W_DEF = 6;
  localparam int unsigned M_W_DEF = 8;
  localparam int unsigned N_W_DEF = 3;
  localparam int unsigned E_W_DEF = 8;
  localparam int unsigned P_W_DEF = 5;
  localparam int unsigned T_W_DEF = 3;
  localparam int unsigned B_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EMIT    = 2'd1,
    ADVANCE = 2'd2,
    DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/psum_index_sequencer_if.sv
// Index tuple stream: one {psum, channel, row, column} beat per valid/ready transfer.
interface psum_index_sequencer_if
  import psum_idx_pkg::*;
#(
  parameter int unsigned F_W = F_W_DEF,
  parameter int unsigned M_W = M_W_DEF,
  parameter int unsigned N_W = N_W_DEF,
  parameter int unsigned E_W = E_W_DEF
);

  logic           out_valid;
  logic           out_ready;
  logic [N_W-1:0] psum_index;
  logic [M_W-1:0] channel_index;
  logic [E_W-1:0] row_index;
  logic [F_W-1:0] col_index;
  logic           out_burst_last;
  logic           out_pass_last;

  modport master (
    output out_valid, psum_index, channel_index, row_index, col_index,
           out_burst_last, out_pass_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, psum_index, channel_index, row_index, col_index,
           out_burst_last, out_pass_last,
    output out_ready
  );

endinterface

// File: rtl/wrap_counter.sv
// Counter that wraps to zero after reaching bound; load has priority over enable.
module wrap_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] bound,
  output logic [WIDTH-1:0] count,
  output logic             at_max
);

  logic [WIDTH-1:0] r_count;

  assign at_max = (r_count == bound);
  assign count  = r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_value;
    end else if (enable) begin
      r_count <= at_max ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/psum_index_sequencer.sv
// Walks a (p, F, n) psum cursor in bursts, one burst per (e, t) group, emitting index tuples.
module psum_index_sequencer
  import psum_idx_pkg::*;
#(
  parameter int unsigned F_W = F_W_DEF,
  parameter int unsigned M_W = M_W_DEF,
  parameter int unsigned N_W = N_W_DEF,
  parameter int unsigned E_W = E_W_DEF,
  parameter int unsigned P_W = P_W_DEF,
  parameter int unsigned T_W = T_W_DEF,
  parameter int unsigned B_W = B_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  clear_m,
  input  logic [F_W-1:0]        cfg_F,
  input  logic [M_W-1:0]        cfg_M,
  input  logic [N_W-1:0]        cfg_n,
  input  logic [E_W-1:0]        cfg_e,
  input  logic [P_W-1:0]        cfg_p,
  input  logic [T_W-1:0]        cfg_t,
  input  logic [B_W-1:0]        cfg_burst,
  psum_index_sequencer_if.master out_if,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned CW = M_W + P_W + T_W;

  state_e r_state, w_next;

  logic [F_W-1:0] r_cfg_F;
  logic [M_W-1:0] r_cfg_M;
  logic [N_W-1:0] r_cfg_n;
  logic [E_W-1:0] r_cfg_e;
  logic [P_W-1:0] r_cfg_p;
  logic [T_W-1:0] r_cfg_t;
  logic [B_W-1:0] r_cfg_burst;

  logic [P_W-1:0] r_p_base;
  logic [F_W-1:0] r_f_base;
  logic [N_W-1:0] r_n_base;
  logic [M_W-1:0] r_m_base;
  logic           r_frozen;

  logic [P_W-1:0] w_p_cnt;
  logic [F_W-1:0] w_f_cnt;
  logic [N_W-1:0] w_n_cnt;
  logic [E_W-1:0] w_e_cnt;
  logic [T_W-1:0] w_t_cnt;
  logic [B_W-1:0] w_unused_beat_cnt;
  logic           w_p_max, w_f_max, w_n_max, w_e_max, w_t_max, w_beat_max;

  logic w_emit, w_adv_st, w_launch, w_accept, w_step;
  logic w_at_final, w_last_grp, w_burst_end, w_rewind, w_commit;

  logic [CW-1:0]     w_chan_sum;
  logic [CW-1:0]     w_m_sum;
  logic [M_W-1:0]    w_m_next;
  logic [CW-M_W-1:0] w_unused_chan_hi;

  assign w_emit      = (r_state == EMIT);
  assign w_adv_st    = (r_state == ADVANCE);
  assign w_launch    = (r_state == IDLE) && start;
  assign w_accept    = w_emit && out_if.out_ready;
  assign w_at_final  = w_p_max && w_f_max && w_n_max;
  assign w_last_grp  = w_e_max && w_t_max;
  assign w_burst_end = w_beat_max || w_at_final;
  assign w_step      = w_accept && !w_at_final;
  assign w_commit    = w_adv_st && w_last_grp;
  // Once the final tuple has been emitted the cursor stays there for the rest
  // of the sweep instead of rewinding, so later groups emit a single beat.
  assign w_rewind    = w_adv_st && !w_last_grp && !r_frozen;

  wrap_counter #(.WIDTH(P_W)) u_p_cnt (
    .clk(clk), .reset(reset),
    .enable(w_step), .load(w_launch || w_rewind),
    .load_value(w_launch ? '0 : r_p_base), .bound(r_cfg_p - P_W'(1)),
    .count(w_p_cnt), .at_max(w_p_max)
  );

  wrap_counter #(.WIDTH(F_W)) u_f_cnt (
    .clk(clk), .reset(reset),
    .enable(w_step && w_p_max), .load(w_launch || w_rewind),
    .load_value(w_launch ? '0 : r_f_base), .bound(r_cfg_F - F_W'(1)),
    .count(w_f_cnt), .at_max(w_f_max)
  );

  wrap_counter #(.WIDTH(N_W)) u_n_cnt (
    .clk(clk), .reset(reset),
    .enable(w_step && w_p_max && w_f_max), .load(w_launch || w_rewind),
    .load_value(w_launch ? '0 : r_n_base), .bound(r_cfg_n - N_W'(1)),
    .count(w_n_cnt), .at_max(w_n_max)
  );

  wrap_counter #(.WIDTH(E_W)) u_e_cnt (
    .clk(clk), .reset(reset),
    .enable(w_adv_st && !w_last_grp && w_t_max), .load(w_launch || w_commit),
    .load_value('0), .bound(r_cfg_e - E_W'(1)),
    .count(w_e_cnt), .at_max(w_e_max)
  );

  wrap_counter #(.WIDTH(T_W)) u_t_cnt (
    .clk(clk), .reset(reset),
    .enable(w_adv_st && !w_last_grp), .load(w_launch || w_commit),
    .load_value('0), .bound(r_cfg_t - T_W'(1)),
    .count(w_t_cnt), .at_max(w_t_max)
  );

  wrap_counter #(.WIDTH(B_W)) u_beat_cnt (
    .clk(clk), .reset(reset),
    .enable(w_accept), .load(w_launch || w_adv_st),
    .load_value('0), .bound(r_cfg_burst - B_W'(1)),
    .count(w_unused_beat_cnt), .at_max(w_beat_max)
  );

  assign w_chan_sum       = CW'(r_m_base) + CW'(w_p_cnt) + CW'(w_t_cnt) * CW'(r_cfg_p);
  assign w_unused_chan_hi = w_chan_sum[CW-1:M_W];
  assign w_m_sum          = CW'(r_m_base) + CW'(r_cfg_p) * CW'(r_cfg_t);
  assign w_m_next         = (w_m_sum >= CW'(r_cfg_M)) ? '0 : w_m_sum[M_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cfg_F     <= '0;
      r_cfg_M     <= '0;
      r_cfg_n     <= '0;
      r_cfg_e     <= '0;
      r_cfg_p     <= '0;
      r_cfg_t     <= '0;
      r_cfg_burst <= '0;
      r_p_base    <= '0;
      r_f_base    <= '0;
      r_n_base    <= '0;
      r_m_base    <= '0;
      r_frozen    <= 1'b0;
    end else begin
      if (r_state == IDLE && clear_m) r_m_base <= '0;
      if (w_launch) begin
        r_cfg_F     <= (cfg_F     == '0) ? F_W'(1) : cfg_F;
        r_cfg_M     <= (cfg_M     == '0) ? M_W'(1) : cfg_M;
        r_cfg_n     <= (cfg_n     == '0) ? N_W'(1) : cfg_n;
        r_cfg_e     <= (cfg_e     == '0) ? E_W'(1) : cfg_e;
        r_cfg_p     <= (cfg_p     == '0) ? P_W'(1) : cfg_p;
        r_cfg_t     <= (cfg_t     == '0) ? T_W'(1) : cfg_t;
        r_cfg_burst <= (cfg_burst == '0) ? B_W'(1) : cfg_burst;
        r_p_base    <= '0;
        r_f_base    <= '0;
        r_n_base    <= '0;
        r_frozen    <= 1'b0;
      end
      if (w_accept && w_at_final) r_frozen <= 1'b1;
      if (w_commit) begin
        r_p_base <= w_p_cnt;
        r_f_base <= w_f_cnt;
        r_n_base <= w_n_cnt;
      end
      if (r_state == DONE) r_m_base <= w_m_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = EMIT;
      EMIT:    if (w_accept && w_burst_end) w_next = (w_last_grp && w_at_final) ? DONE : ADVANCE;
      ADVANCE: w_next = EMIT;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    out_if.out_valid      = w_emit;
    out_if.out_burst_last = w_emit && w_burst_end;
    out_if.out_pass_last  = w_emit && w_at_final && w_last_grp;
    out_if.psum_index     = w_n_cnt;
    out_if.channel_index  = w_chan_sum[M_W-1:0];
    out_if.row_index      = w_e_cnt;
    out_if.col_index      = w_f_cnt;
    busy                  = w_emit || w_adv_st;
    done                  = (r_state == DONE);
  end

endmodule

// File: tb/tb_psum_index_sequencer.sv
// Table-driven bench with a reference sweep model feeding a beat scoreboard.
module tb_psum_index_sequencer;

  localparam int unsigned F_W = 6, M_W = 8, N_W = 3, E_W = 8, P_W = 5, T_W = 3, B_W = 4;

  logic clk = 1'b0;
  logic reset, start, clear_m, busy, done;
  logic [F_W-1:0] cfg_F;
  logic [M_W-1:0] cfg_M;
  logic [N_W-1:0] cfg_n;
  logic [E_W-1:0] cfg_e;
  logic [P_W-1:0] cfg_p;
  logic [T_W-1:0] cfg_t;
  logic [B_W-1:0] cfg_burst;

  psum_index_sequencer_if #(.F_W(F_W), .M_W(M_W), .N_W(N_W), .E_W(E_W)) bus();

  psum_index_sequencer #(
    .F_W(F_W), .M_W(M_W), .N_W(N_W), .E_W(E_W), .P_W(P_W), .T_W(T_W), .B_W(B_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .clear_m(clear_m),
    .cfg_F(cfg_F), .cfg_M(cfg_M), .cfg_n(cfg_n), .cfg_e(cfg_e),
    .cfg_p(cfg_p), .cfg_t(cfg_t), .cfg_burst(cfg_burst),
    .out_if(bus), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int F, M, n, e, p, t, burst;
    bit clr;
    int rmode;
    int exp_beats, exp_busy, exp_chan0;
  } vec_t;

  int tests = 0, fails = 0;
  int model_mb = 0;
  int ncyc = 0, pass_beats = 0, last_beat_ncyc = 0, first_chan = 0;
  logic [31:0] exp_q[$];
  logic [31:0] w_tuple, prev_tuple;
  bit prev_stall = 0;
  logic [7:0]  log_row, log_bl, log_pl;
  logic [15:0] log_pf;
  logic [31:0] log_ch;
  bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  assign w_tuple = {5'b0, bus.psum_index, bus.channel_index, bus.row_index,
                    bus.col_index, bus.out_burst_last, bus.out_pass_last};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pack_t(input int n, input int ch, input int row,
                                         input int col, input bit bl, input bit pl);
    logic [31:0] r;
    r = {5'b0, n[N_W-1:0], ch[M_W-1:0], row[E_W-1:0], col[F_W-1:0], bl, pl};
    return r;
  endfunction

  // Linear-index reference: cursor c enumerates p fastest, then F, then n.
  task automatic build_model(input vec_t v);
    int P, F, N, E, T, B, total, base, c, beats, pushed;
    bit frozen, fin, at_fin, lg, bl;
    P = (v.p == 0) ? 1 : v.p;  F = (v.F == 0) ? 1 : v.F;  N = (v.n == 0) ? 1 : v.n;
    E = (v.e == 0) ? 1 : v.e;  T = (v.t == 0) ? 1 : v.t;  B = (v.burst == 0) ? 1 : v.burst;
    total = P * F * N; base = 0; frozen = 0; fin = 0; pushed = 0;
    while (!fin && pushed < 4000) begin
      for (int e = 0; e < E && !fin; e++) begin
        for (int t = 0; t < T && !fin; t++) begin
          c = frozen ? total - 1 : base;
          beats = 0;
          lg = (e == E - 1) && (t == T - 1);
          forever begin
            beats++;
            at_fin = (c == total - 1);
            bl = at_fin || (beats == B);
            exp_q.push_back(pack_t(c / (P * F), (model_mb + c % P + t * P) % (1 << M_W),
                                   e, (c / P) % F, bl, at_fin && lg));
            pushed++;
            if (at_fin) frozen = 1;
            if (bl) break;
            c++;
          end
          if (lg) begin
            if (at_fin) fin = 1;
            else base = c + 1;
          end
        end
      end
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] e;
    ncyc++;
    if (prev_stall && bus.out_valid) chk("stall_hold", w_tuple, prev_tuple);
    prev_stall = bus.out_valid && !bus.out_ready;
    prev_tuple = w_tuple;
    if (bus.out_valid && bus.out_ready) begin
      if (pass_beats == 0) first_chan = int'(bus.channel_index);
      pass_beats++;
      last_beat_ncyc = ncyc;
      log_row = {log_row[6:0], bus.row_index[0]};
      log_pf  = {log_pf[13:0], bus.channel_index[0], bus.col_index[0]};
      log_bl  = {log_bl[6:0], bus.out_burst_last};
      log_pl  = {log_pl[6:0], bus.out_pass_last};
      log_ch  = {log_ch[23:0], bus.channel_index};
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL extra_beat: got 0x%0h expected no beat", w_tuple);
      end else begin
        e = exp_q.pop_front();
        chk("beat", w_tuple, e);
      end
    end
  end

  task automatic load_cfg(input vec_t v);
    cfg_F = F_W'(v.F); cfg_M = M_W'(v.M); cfg_n = N_W'(v.n); cfg_e = E_W'(v.e);
    cfg_p = P_W'(v.p); cfg_t = T_W'(v.t); cfg_burst = B_W'(v.burst);
  endtask

  task automatic run_pass(input vec_t v);
    int busy_c, stall_c, k, done_n, P, T, M;
    bit seen;
    load_cfg(v);
    clear_m = v.clr;
    if (v.clr) model_mb = 0;
    build_model(v);
    pass_beats = 0; log_row = '0; log_pf = '0; log_bl = '0; log_pl = '0; log_ch = '0;
    bus.out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; clear_m = 1'b0;
    chk("start_latency", bus.out_valid, 1);
    busy_c = 0; stall_c = 0; seen = 0; k = 0; done_n = 0;
    while (!seen && k < 3000) begin
      @(negedge clk); #1;
      if (busy) busy_c++;
      if (bus.out_valid && !bus.out_ready) stall_c++;
      if (done) begin
        seen = 1;
        done_n = ncyc;
      end else begin
        @(posedge clk); #1;
        k++;
        if (v.rmode == 1) bus.out_ready = pat[k % 4];
      end
    end
    chk("done_seen", seen, 1);
    chk("beat_count", pass_beats, v.exp_beats);
    chk("beats_left", exp_q.size(), 0);
    exp_q.delete();
    chk("first_chan", first_chan, v.exp_chan0);
    chk("busy_cycles", busy_c, v.exp_busy + stall_c);
    chk("done_gap", done_n - last_beat_ncyc, 1);
    @(posedge clk); #1;
    chk("done_width", {busy, done}, 0);
    bus.out_ready = 1'b1;
    P = (v.p == 0) ? 1 : v.p; T = (v.t == 0) ? 1 : v.t; M = (v.M == 0) ? 1 : v.M;
    model_mb = model_mb + P * T;
    if (model_mb >= M) model_mb = 0;
  endtask

  vec_t vecs[8];

  initial begin
    int k;
    vec_t c1;
    vecs[0] = '{2, 8, 1, 2, 2, 1, 3, 1'b1, 0, 8, 11, 0};
    vecs[1] = '{2, 8, 1, 2, 2, 1, 3, 1'b0, 0, 8, 11, 2};
    vecs[2] = '{2, 8, 1, 2, 2, 1, 3, 1'b0, 0, 8, 11, 4};
    vecs[3] = '{2, 8, 1, 2, 2, 1, 3, 1'b0, 0, 8, 11, 6};
    vecs[4] = '{2, 8, 1, 2, 2, 1, 3, 1'b0, 1, 8, 11, 0};
    vecs[5] = '{1, 16, 1, 1, 1, 3, 1, 1'b1, 0, 3, 5, 0};
    vecs[6] = '{0, 0, 0, 0, 0, 0, 0, 1'b0, 0, 1, 1, 0};
    vecs[7] = '{2, 8, 1, 2, 2, 1, 3, 1'b0, 0, 8, 11, 0};
    c1 = vecs[1];

    reset = 1'b1; start = 1'b0; clear_m = 1'b0; bus.out_ready = 1'b1;
    load_cfg(c1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctrl", {bus.out_valid, busy, done, bus.out_burst_last, bus.out_pass_last}, 0);
    chk("rst_idx", w_tuple, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      run_pass(vecs[i]);
      if (i == 0) begin
        chk("c1_rows", log_row, 8'h1D);
        chk("c1_pf", log_pf, 16'h249F);
        chk("c1_burst_last", log_bl, 8'h27);
        chk("c1_pass_last", log_pl, 8'h01);
      end
      if (i == 5) chk("c4_chan_seq", log_ch[23:0], 24'h000102);
    end

    // Abort a pass in its second burst with an asynchronous reset.
    load_cfg(c1);
    build_model(c1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (!(bus.out_valid && bus.row_index == 1) && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk("rst_burst2_reached", bus.row_index, 1);
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    chk("rst_mid_ctrl", {bus.out_valid, busy, done, bus.out_burst_last, bus.out_pass_last}, 0);
    chk("rst_mid_idx", w_tuple, 0);
    @(posedge clk); #1;
    chk("rst_hold_idle", {bus.out_valid, busy, done}, 0);
    reset = 1'b0;
    exp_q.delete();
    model_mb = 0;
    @(posedge clk); #1;

    for (int i = 6; i < 8; i++) run_pass(vecs[i]);
    chk("zero_cfg_tuple", log_bl[0] & log_pl[0], 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
